// File: rtl/filter_gpu_pkg.sv
// Shared definitions for the vector memory stage: lane geometry, the
// vector type and the serialiser state encoding.
package filter_gpu_pkg;

  localparam int LANES  = 3;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 10;

  typedef logic [LANES-1:0][DATA_W-1:0] vec_t;

  // IDLE : waiting, lane 0 issued straight from the inputs on a request
  // L1   : lane 1 issued, lane 0 read data arrives
  // L2   : lane 2 issued, lane 1 read data arrives
  // CAP  : nothing issued, lane 2 read data arrives (reads only)
  // DONE : pipeline released for one cycle while M still holds the instruction
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_CAP  = 3'd3,
    ST_DONE = 3'd4
  } mem_state_e;

endpackage

// File: rtl/vector_mem_stage.sv
// Memory stage for 3-lane vector loads/stores. One vector access is
// serialised onto a single-port RAM, lane 0 first, while the earlier
// pipeline stages are stalled. The FSM is written for exactly three lanes.
module vector_mem_stage
  import filter_gpu_pkg::*;
#(
  parameter int LANES  = filter_gpu_pkg::LANES,
  parameter int DATA_W = filter_gpu_pkg::DATA_W,
  parameter int ADDR_W = filter_gpu_pkg::ADDR_W
) (
  input  logic                             CLK,
  input  logic                             RST,
  // datapath side
  input  logic                             MemWriteM,
  input  logic                             ReadReqM,
  input  logic [ADDR_W-1:0]                A1M,
  input  logic [ADDR_W-1:0]                A2M,
  input  logic [ADDR_W-1:0]                A3M,
  input  logic [LANES-1:0][DATA_W-1:0]     writeDataM,
  output logic [LANES-1:0][DATA_W-1:0]     RDM,
  output logic                             StallM,
  // RAM side
  output logic [ADDR_W-1:0]                ram_addr,
  output logic                             ram_we,
  output logic [DATA_W-1:0]                ram_wdata,
  input  logic [DATA_W-1:0]                ram_rdata
);

  mem_state_e                      state_q, state_d;
  logic                            is_wr_q, is_wr_d;
  logic [ADDR_W-1:0]               a2_q, a2_d;
  logic [ADDR_W-1:0]               a3_q, a3_d;
  // lane 0 store data goes out directly from the inputs, so only 1..2 are kept
  logic [LANES-1:1][DATA_W-1:0]    wdata_q, wdata_d;
  // read data of lanes 0 and 1 waits here until lane 2 arrives
  logic [LANES-2:0][DATA_W-1:0]    cap_q, cap_d;
  logic [LANES-1:0][DATA_W-1:0]    rdm_q, rdm_d;

  logic                            req;
  logic [ADDR_W-1:0]               addr_c;
  logic                            we_c;
  logic [DATA_W-1:0]               wdata_c;
  logic                            stall_c;

  assign req = MemWriteM | ReadReqM;

  // Next-state, latch enables and RAM/stall drive for the serialiser
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdm_d   = rdm_q;
    addr_c  = '0;
    we_c    = 1'b0;
    wdata_c = '0;
    stall_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // a simultaneous load and store request is handled as a store
          addr_c  = A1M;
          we_c    = MemWriteM;
          wdata_c = MemWriteM ? writeDataM[0] : '0;
          stall_c = 1'b1;
          is_wr_d = MemWriteM;
          a2_d    = A2M;
          a3_d    = A3M;
          wdata_d = writeDataM[LANES-1:1];
          state_d = ST_L1;
        end
      end
      ST_L1: begin
        addr_c  = a2_q;
        we_c    = is_wr_q;
        wdata_c = is_wr_q ? wdata_q[1] : '0;
        stall_c = 1'b1;
        if (!is_wr_q) cap_d[0] = ram_rdata;
        state_d = ST_L2;
      end
      ST_L2: begin
        addr_c  = a3_q;
        we_c    = is_wr_q;
        wdata_c = is_wr_q ? wdata_q[2] : '0;
        stall_c = 1'b1;
        if (!is_wr_q) cap_d[1] = ram_rdata;
        state_d = is_wr_q ? ST_DONE : ST_CAP;
      end
      ST_CAP: begin
        // the whole load vector becomes visible at once on leaving CAP
        stall_c = 1'b1;
        rdm_d   = {ram_rdata, cap_q};
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // requests seen here belong to the instruction just completed
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers; reset abandons any access in progress
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      is_wr_q <= 1'b0;
      a2_q    <= '0;
      a3_q    <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdm_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdm_q   <= rdm_d;
    end
  end

  // Reset gates the write strobe and stall immediately, even mid-access
  assign ram_we    = we_c & ~RST;
  assign StallM    = stall_c & ~RST;
  assign ram_addr  = addr_c;
  assign ram_wdata = wdata_c;
  assign RDM       = rdm_q;

endmodule
